alu_seq_unit: RTL

Parametrised, handshaked successor to the 4-bit synchronous arithmetic unit. It takes `M`-bit two's-complement operands through a valid/ready input port. Single-cycle ops return a result one cycle after acceptance; a new multi-cycle signed multiply runs on an iterative shift-add datapath. Results are held in an output register behind a valid/ready output port, so the block can sit between stalling producers and consumers in the datapath.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_shift_add_mul.sv | 69 ++++++
 rtl/alu_seq_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state enums and status encoding for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SUB  = 3'b000,
        OP_COMP = 3'b001,
        OP_SUM  = 3'b010,
        OP_CONV = 3'b011,
        OP_MUL  = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } alu_state_e;

    localparam logic [3:0]  ST_ERR  = 4'b1001;
    localparam int unsigned ST_EVEN = 2;
    localparam int unsigned ST_ONES = 1;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative signed multiplier: magnitudes are shift-added over M steps, then the
// sign is applied and the full-precision product is range-checked against M bits.
module alu_shift_add_mul #(
    parameter int unsigned M = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         done_c,
    output logic [M-1:0] result_c,
    output logic         err_c
);

    localparam int unsigned CW = $clog2(M + 1);
    localparam int unsigned PW = 2 * M;

    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [M-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          run;
    logic [M-1:0]  abs_a;
    logic [M-1:0]  abs_b;
    logic [PW-1:0] prod;

    always_comb begin
        abs_a = a[M-1] ? (~a + M'(1)) : a;
        abs_b = b[M-1] ? (~b + M'(1)) : b;
    end

    // One partial product per edge; the extra edge at cnt == 0 is the finalize step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            run    <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {M'(0), abs_a};
            mplier <= abs_b;
            cnt    <= CW'(M);
            neg    <= a[M-1] ^ b[M-1];
            run    <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                acc    <= acc + (mplier[0] ? mcand : PW'(0));
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                run <= 1'b0;
            end
        end
    end

    always_comb begin
        prod     = neg ? (~acc + PW'(1)) : acc;
        done_c   = run && (cnt == '0);
        result_c = prod[M-1:0];
        err_c    = !((prod[PW-1:M-1] == '0) || (prod[PW-1:M-1] == '1));
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ops plus an iterative MUL, results held in a
// registered valid/ready output stage.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned M   = 8,
    parameter int unsigned OPW = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [OPW-1:0] i_op,
    input  logic [M-1:0]   i_arg_A,
    input  logic [M-1:0]   i_arg_B,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [M-1:0]   o_result,
    output logic [3:0]     o_status
);

    localparam int unsigned IW = $clog2(M);
    localparam int unsigned XW = M + 2;

    alu_state_e    state;
    alu_state_e    state_nx;
    logic          accept_c;
    logic          is_mul_c;
    logic          load_op_c;
    logic          mul_start_c;
    logic          mul_done_c;
    logic [M-1:0]  mul_res;
    logic          mul_err;
    logic [XW-1:0] a_x;
    logic [XW-1:0] b_x;
    logic [XW-1:0] sub_x;
    logic [XW-1:0] sum_x;
    logic [M-1:0]  neg_a;
    logic [M-1:0]  clr_mask;
    logic [M-1:0]  op_res;
    logic          op_err;

    function automatic logic fits_m(input logic [XW-1:0] x);
        return (x[XW-1:M-1] == '0) || (x[XW-1:M-1] == '1);
    endfunction

    function automatic logic [3:0] status_of(input logic err, input logic [M-1:0] res);
        logic [3:0] st;
        st = '0;
        if (err) begin
            st = ST_ERR;
        end else begin
            st[ST_EVEN] = ~^res;
            st[ST_ONES] = &res;
        end
        return st;
    endfunction

    alu_shift_add_mul #(.M(M)) u_mul (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .start    (mul_start_c),
        .a        (i_arg_A),
        .b        (i_arg_B),
        .done_c   (mul_done_c),
        .result_c (mul_res),
        .err_c    (mul_err)
    );

    // Single-cycle ops evaluated at M+2 bits so the range check sees the true value.
    always_comb begin
        a_x      = {{2{i_arg_A[M-1]}}, i_arg_A};
        b_x      = {{2{i_arg_B[M-1]}}, i_arg_B};
        sub_x    = a_x - {b_x[XW-2:0], 1'b0};
        sum_x    = a_x + b_x;
        neg_a    = ~i_arg_A + M'(1);
        clr_mask = ~(M'(1) << i_arg_B[IW-1:0]);
        op_err   = 1'b0;
        op_res   = '0;
        case (i_op)
            OPW'(OP_SUB): begin
                op_err = !fits_m(sub_x);
                op_res = sub_x[M-1:0];
            end
            OPW'(OP_COMP): op_res = M'($signed(i_arg_A) < $signed(i_arg_B));
            OPW'(OP_SUM): begin
                op_err = !fits_m(sum_x);
                op_res = sum_x[M-1:0] & clr_mask;
            end
            OPW'(OP_CONV): begin
                op_err = (i_arg_A == {1'b1, {(M-1){1'b0}}});
                op_res = i_arg_A[M-1] ? (neg_a | {1'b1, {(M-1){1'b0}}}) : i_arg_A;
            end
            OPW'(OP_MUL): op_err = 1'b0;
            default:      op_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept_c) state_nx = is_mul_c ? S_BUSY : S_DONE;
            S_BUSY: if (mul_done_c) state_nx = S_DONE;
            S_DONE: begin
                if (accept_c) begin
                    state_nx = is_mul_c ? S_BUSY : S_DONE;
                end else if (i_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Ready depends only on state and i_ready, never on i_valid.
    always_comb begin
        o_ready = 1'b0;
        case (state)
            S_IDLE:  o_ready = 1'b1;
            S_DONE:  o_ready = i_ready;
            default: o_ready = 1'b0;
        endcase
        is_mul_c    = (i_op == OPW'(OP_MUL));
        accept_c    = i_valid && o_ready;
        load_op_c   = accept_c && !is_mul_c;
        mul_start_c = accept_c && is_mul_c;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_valid <= (state_nx == S_DONE);
            if (load_op_c) begin
                o_result <= op_err ? '0 : op_res;
                o_status <= status_of(op_err, op_res);
            end else if (mul_done_c) begin
                o_result <= mul_err ? '0 : mul_res;
                o_status <= status_of(mul_err, mul_res);
            end
        end
    end

endmodule
